// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Brief    : Shared constants, state encoding and length-byte helper for the
//            MD block padder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package md_pkg;

    localparam int         MD_BLOCK_W     = 512;
    localparam int         MD_BLOCK_BYTES = 64;
    localparam int         MD_LEN_OFFSET  = 56;
    localparam logic [7:0] MD_PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PAD    = 2'd1,
        OUT    = 2'd2,
        LENBLK = 2'd3
    } md_state_e;

    // Byte k (0 = most significant) of the big-endian 64-bit length field.
    function automatic logic [7:0] md_len_byte(input logic [63:0] len, input int k);
        return len[63-8*k -: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_block_padder.sv
// ============================================================================
// Module   : md_block_padder
// Brief    : Packs a byte stream into 512-bit blocks and applies MD padding
//            (0x80, zero fill, 64-bit bit length) for the hash core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_block_padder
    import md_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [MD_BLOCK_W-1:0] m_block,
    output logic                  m_valid,
    output logic                  m_last_block,
    input  logic                  m_ready
);

    md_state_e        state_q,    state_d;
    logic [7:0]       buf_q       [MD_BLOCK_BYTES];
    logic [7:0]       buf_d       [MD_BLOCK_BYTES];
    logic [6:0]       idx_q,      idx_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic             final_q,    final_d;
    logic             need_len_q, need_len_d;
    logic             need_80_q,  need_80_d;
    logic [63:0]      len_ext;

    assign len_ext = 64'(len_q);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        len_d      = len_q;
        final_d    = final_q;
        need_len_d = need_len_q;
        need_80_d  = need_80_q;

        case (state_q)
            FILL: begin
                if (s_valid) begin
                    buf_d[idx_q[5:0]] = s_data;
                    idx_d             = idx_q + 7'd1;
                    len_d             = len_q + LEN_W'(8);
                    // s_last wins over a full block so a 64-byte tail still pads.
                    if (s_last) begin
                        state_d = PAD;
                    end else if (idx_q == 7'(MD_BLOCK_BYTES - 1)) begin
                        state_d = OUT;
                    end
                end
            end

            PAD: begin
                if (idx_q < 7'(MD_LEN_OFFSET)) begin
                    buf_d[idx_q[5:0]] = MD_PAD_BYTE;
                    for (int k = 0; k < 8; k++) begin
                        buf_d[MD_LEN_OFFSET + k] = md_len_byte(len_ext, k);
                    end
                    final_d = 1'b1;
                end else if (idx_q < 7'(MD_BLOCK_BYTES)) begin
                    buf_d[idx_q[5:0]] = MD_PAD_BYTE;
                    final_d           = 1'b0;
                    need_len_d        = 1'b1;
                    need_80_d         = 1'b0;
                end else begin
                    final_d    = 1'b0;
                    need_len_d = 1'b1;
                    need_80_d  = 1'b1;
                end
                state_d = OUT;
            end

            OUT: begin
                if (m_ready) begin
                    for (int i = 0; i < MD_BLOCK_BYTES; i++) begin
                        buf_d[i] = '0;
                    end
                    idx_d = '0;
                    if (need_len_q) begin
                        state_d = LENBLK;
                    end else if (final_q) begin
                        state_d = FILL;
                        len_d   = '0;
                        final_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            LENBLK: begin
                if (need_80_q) begin
                    buf_d[0] = MD_PAD_BYTE;
                end
                for (int k = 0; k < 8; k++) begin
                    buf_d[MD_LEN_OFFSET + k] = md_len_byte(len_ext, k);
                end
                final_d    = 1'b1;
                need_len_d = 1'b0;
                need_80_d  = 1'b0;
                state_d    = OUT;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            for (int i = 0; i < MD_BLOCK_BYTES; i++) begin
                buf_q[i] <= '0;
            end
            idx_q      <= '0;
            len_q      <= '0;
            final_q    <= 1'b0;
            need_len_q <= 1'b0;
            need_80_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < MD_BLOCK_BYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
            idx_q      <= idx_d;
            len_q      <= len_d;
            final_q    <= final_d;
            need_len_q <= need_len_d;
            need_80_q  <= need_80_d;
        end
    end

    // Ready is masked by reset so nothing upstream sees a handshake while held.
    assign s_ready      = rst_n & (state_q == FILL);
    assign m_valid      = (state_q == OUT);
    assign m_last_block = m_valid & final_q;

    always_comb begin
        m_block = '0;
        for (int i = 0; i < MD_BLOCK_BYTES; i++) begin
            m_block[MD_BLOCK_W-1-8*i -: 8] = buf_q[i];
        end
    end

endmodule

`default_nettype wire
